// File: rtl/pcs_sync_ctrl_pkg.sv
// Shared state encoding, default timing constants and sizing helper for the
// PCS sync bring-up controller.
package pcs_ctrl_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    OFF        = 3'd0,
    RST_HOLD   = 3'd1,
    WAIT_SYNC  = 3'd2,
    LINK_CHECK = 3'd3,
    LINK_UP    = 3'd4
  } state_e;

  localparam int unsigned DEF_RESET_CYCLES = 4;
  localparam int unsigned DEF_SYNC_TIMEOUT = 16;
  localparam int unsigned DEF_LINK_TIMER   = 8;
  localparam int unsigned DEF_CNT_W        = 4;

  function automatic int unsigned max3(input int unsigned a, b, c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pcs_sync_ctrl_if.sv
// Board/management-side and sync-block-side signals of the bring-up controller.
interface pcs_sync_ctrl_if #(
  parameter int unsigned CNT_W = 4
);
  logic             power_good;
  logic             code_sync_status;
  logic             power_on;
  logic             sync_reset;
  logic             pudi_enable;
  logic             link_ok;
  logic [2:0]       state;
  logic [CNT_W-1:0] resync_count;
  logic             timeout;

  modport master (
    input  power_good, code_sync_status,
    output power_on, sync_reset, pudi_enable, link_ok, state, resync_count, timeout
  );

  modport slave (
    output power_good, code_sync_status,
    input  power_on, sync_reset, pudi_enable, link_ok, state, resync_count, timeout
  );
endinterface

// File: rtl/pcs_sync_ctrl_timer.sv
// Shared dwell counter: clear has priority over enable; done flags the last
// cycle before the current state's limit is reached.
module pcs_timer #(
  parameter int unsigned W = 5
) (
  input  logic         Clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic         done
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)     count_d = '0;
    else if (en) count_d = count_q + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign done = (count_q == last);

endmodule

// File: rtl/pcs_sync_ctrl.sv
// Bring-up FSM for the PCS sync block: power sequencing, reset hold, sync
// timeout with saturating retry count, and link qualification.
module pcs_sync_ctrl
  import pcs_ctrl_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int unsigned SYNC_TIMEOUT = DEF_SYNC_TIMEOUT,
  parameter int unsigned LINK_TIMER   = DEF_LINK_TIMER,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic            Clk,
  input  logic            mr_main_reset,
  pcs_sync_ctrl_if.master bus
);

  localparam int unsigned TMR_W = $clog2(max3(RESET_CYCLES, SYNC_TIMEOUT, LINK_TIMER) + 1);

  localparam logic [TMR_W-1:0] RST_LAST  = TMR_W'(RESET_CYCLES - 1);
  localparam logic [TMR_W-1:0] SYNC_LAST = TMR_W'(SYNC_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] LINK_LAST = TMR_W'(LINK_TIMER - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] resync_count_q, resync_count_d;
  logic             timeout_q, timeout_d;

  logic             tmr_clr, tmr_en, tmr_done;
  logic [TMR_W-1:0] tmr_last;

  pcs_timer #(.W(TMR_W)) u_timer (
    .Clk  (Clk),
    .rst  (mr_main_reset),
    .clr  (tmr_clr),
    .en   (tmr_en),
    .last (tmr_last),
    .done (tmr_done)
  );

  always_comb begin
    state_d        = state_q;
    resync_count_d = resync_count_q;
    timeout_d      = 1'b0;
    tmr_clr        = 1'b0;
    tmr_en         = 1'b0;
    tmr_last       = '0;

    // Losing power drops us to OFF from anywhere; retry history survives.
    if (!bus.power_good && state_q != OFF) begin
      state_d = OFF;
      tmr_clr = 1'b1;
    end else begin
      unique case (state_q)
        OFF: begin
          tmr_clr = 1'b1;
          if (bus.power_good) state_d = RST_HOLD;
        end
        RST_HOLD: begin
          tmr_last = RST_LAST;
          if (tmr_done) begin
            state_d = WAIT_SYNC;
            tmr_clr = 1'b1;
          end else begin
            tmr_en = 1'b1;
          end
        end
        WAIT_SYNC: begin
          tmr_last = SYNC_LAST;
          // Sync arriving on the expiry cycle wins over the timeout.
          if (bus.code_sync_status) begin
            state_d = LINK_CHECK;
            tmr_clr = 1'b1;
          end else if (tmr_done) begin
            state_d   = RST_HOLD;
            tmr_clr   = 1'b1;
            timeout_d = 1'b1;
            if (resync_count_q != {CNT_W{1'b1}}) resync_count_d = resync_count_q + 1'b1;
          end else begin
            tmr_en = 1'b1;
          end
        end
        LINK_CHECK: begin
          tmr_last = LINK_LAST;
          if (!bus.code_sync_status) begin
            state_d = WAIT_SYNC;
            tmr_clr = 1'b1;
          end else if (tmr_done) begin
            state_d = LINK_UP;
            tmr_clr = 1'b1;
          end else begin
            tmr_en = 1'b1;
          end
        end
        LINK_UP: begin
          tmr_clr = 1'b1;
          if (!bus.code_sync_status) state_d = WAIT_SYNC;
        end
        default: begin
          state_d = OFF;
          tmr_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (mr_main_reset) begin
      state_q        <= OFF;
      resync_count_q <= '0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      resync_count_q <= resync_count_d;
      timeout_q      <= timeout_d;
    end
  end

  assign bus.power_on     = (state_q != OFF);
  assign bus.sync_reset   = (state_q == OFF) || (state_q == RST_HOLD);
  assign bus.pudi_enable  = (state_q == WAIT_SYNC) || (state_q == LINK_CHECK) || (state_q == LINK_UP);
  assign bus.link_ok      = (state_q == LINK_UP);
  assign bus.state        = state_q;
  assign bus.resync_count = resync_count_q;
  assign bus.timeout      = timeout_q;

endmodule
